pll_lock_rst_seq: RTL

- Reset/lock sequencer on the free-running 50 MHz init clock, directly downstream of the Ethernet PLL wrapper.
- Consumes the PLL lock output and drives the PLL reset input.
- Qualifies lock over a stability window and releases a held system reset to the Ethernet logic only after lock is proven stable.
- Retries PLL reset on lock timeout; after MAX_RETRY timeouts it latches a fault.

---
 rtl/pll_seq_pkg.sv | 18 +
 rtl/pll_lock_rst_seq_if.sv | 13 +
 rtl/sync_2ff.sv | 22 ++
 rtl/pll_lock_rst_seq.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL lock/reset sequencer.
// Defaults assume the 50 MHz init clock (20 ns period).
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PRST = 3'd0,
    ST_WAIT = 3'd1,
    ST_STAB = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } state_e;

  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
  localparam int DEF_LOCK_STABLE_CYC  = 5000;
  localparam int DEF_MAX_RETRY        = 7;

endpackage

// File: rtl/pll_lock_rst_seq_if.sv
// PLL-facing and downstream signals of the lock/reset sequencer.
// master = sequencer side, slave = PLL wrapper / Ethernet logic side.
interface pll_lock_rst_seq_if;
  logic       pll_lock_i;
  logic       pll_rst_o;
  logic       lock_o;
  logic       sys_rst_o;
  logic [2:0] retry_cnt_o;
  logic       fail_o;

  modport master (input pll_lock_i, output pll_rst_o, lock_o, sys_rst_o, retry_cnt_o, fail_o);
  modport slave  (output pll_lock_i, input pll_rst_o, lock_o, sys_rst_o, retry_cnt_o, fail_o);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with synchronous active-high clear.
// Output lags the input by two clock edges.
module sync_2ff (
  input  logic clk,
  input  logic clr,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_rst_seq.sv
// PLL reset pulse, lock qualification and downstream reset release, with
// bounded retries and a sticky fault once all attempts time out.
module pll_lock_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic               init_clk,
  input  logic               reset,
  pll_lock_rst_seq_if.master bus
);
  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYC - 1);
  localparam logic [PW-1:0] P_MAX  = PW'(RST_PULSE_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(LOCK_TIMEOUT_CYC);
  localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(LOCK_STABLE_CYC);
  localparam logic [2:0]    R_MAX  = 3'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [2:0]    retry_q, retry_d;
  logic          pll_rst_q, lock_q, sys_rst_q, fail_q;
  logic          lk, timeout;

  sync_2ff u_lock_sync (
    .clk (init_clk),
    .clr (reset),
    .d_i (bus.pll_lock_i),
    .q_o (lk)
  );

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    retry_d = retry_q;
    timeout = 1'b0;
    case (state_q)
      ST_PRST: begin
        pcnt_d = (pcnt_q == P_MAX) ? pcnt_q : pcnt_q + 1'b1;
        if (pcnt_q == P_LAST) begin
          state_d = ST_WAIT;
          pcnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        tcnt_d = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + 1'b1;
        if (lk) begin
          state_d = ST_STAB;
          scnt_d  = '0;
        end else if (tcnt_q >= T_LAST) begin
          timeout = 1'b1;
        end
      end
      ST_STAB: begin
        // attempt timer keeps running so a flapping lock still times out
        tcnt_d = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + 1'b1;
        if (lk && scnt_q >= S_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (tcnt_q >= T_LAST) begin
          timeout = 1'b1;
        end else if (!lk) begin
          state_d = ST_WAIT;
        end else begin
          scnt_d = (scnt_q == S_MAX) ? scnt_q : scnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lk) begin
          state_d = ST_PRST;
          pcnt_d  = '0;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_PRST;
    endcase

    if (timeout) begin
      retry_d = retry_q + 3'd1;
      if (retry_d == R_MAX) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_PRST;
        pcnt_d  = '0;
      end
    end
  end

  // outputs are decoded from the next state so they register alongside it
  always_ff @(posedge init_clk) begin
    if (reset) begin
      state_q   <= ST_PRST;
      pcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      lock_q    <= 1'b0;
      sys_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == ST_PRST) || (state_d == ST_FAIL);
      lock_q    <= (state_d == ST_RUN);
      sys_rst_q <= (state_d != ST_RUN);
      fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign bus.pll_rst_o   = pll_rst_q;
  assign bus.lock_o      = lock_q;
  assign bus.sys_rst_o   = sys_rst_q;
  assign bus.retry_cnt_o = retry_q;
  assign bus.fail_o      = fail_q;
endmodule
